// File: rtl/sub16_digit_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : sub16_digit_serial_if
// Description : Operand/result valid-ready bundle for sub16_digit_serial.
//               The ovf signal exists only when SUB16_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface sub16_digit_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SUB16_OVF_EN
    logic             ovf;
`endif

    // Producer of operands and consumer of results
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
`ifdef SUB16_OVF_EN
        , input ovf
`endif
    );

    // The subtractor itself
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
`ifdef SUB16_OVF_EN
        , output ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/sub16_digit_serial.sv
`default_nettype none
// ============================================================================
// Module      : sub16_digit_serial
// Description : Digit-serial subtractor, diff = a - b mod 2^WIDTH plus final
//               borrow, DIGIT bits per cycle, LSB digit first. Operands enter
//               through a valid/ready port, results leave through another.
//               Optional macro SUB16_OVF_EN adds the signed-overflow output.
//               WIDTH must be a multiple of DIGIT with at least two digits.
// Revision    : 1.0 - initial release
// ============================================================================
module sub16_digit_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input wire                clk,
    input wire                rst_n,
    sub16_digit_serial_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int RW   = WIDTH - DIGIT;   // digits collected before the final one

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [RW-1:0]    res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;      // running borrow between digits
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT:0]   w_sub;
    logic             w_last;
    logic             w_accept;

    // One digit of subtraction; a negative result shows up as bit DIGIT set
    assign w_sub    = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
    assign w_last   = (cnt_q == CW'(NDIG - 1));
    assign w_accept = (state_q == IDLE) && bus.in_valid;

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (w_last)        state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, shift one digit per RUN cycle,
    // publish diff/borrow only on the final RUN edge so they stay stable otherwise
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        brw_d    = brw_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        if (w_accept) begin
            a_d   = bus.a;
            b_d   = bus.b;
            brw_d = 1'b0;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            res_d = RW'({w_sub[DIGIT-1:0], res_q} >> DIGIT);
            brw_d = w_sub[DIGIT];
            cnt_d = cnt_q + CW'(1);
            if (w_last) begin
                diff_d   = {w_sub[DIGIT-1:0], res_q};
                borrow_d = w_sub[DIGIT];
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            brw_q    <= brw_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef SUB16_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    // Operand sign bits are kept aside because a/b shift away during RUN
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (w_accept) begin
            a_msb_d = bus.a[WIDTH-1];
            b_msb_d = bus.b[WIDTH-1];
        end else if ((state_q == RUN) && w_last) begin
            ovf_d = (a_msb_q ^ b_msb_q) & (a_msb_q ^ w_sub[DIGIT-1]);
        end
    end

    // Overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
endmodule
`default_nettype wire
